mem_access_unit: RTL and testbench

Load/store sequencer in front of the data memory of the VLIW MEM stage. It accepts one word-addressed load or store per request from the MEM-stage issue slot and drives a single-port synchronous memory port. It returns load data with the originating slot tag under a valid/ready handshake. It can optionally run a post-reset sweep that writes `mem[i] = i` into every word before accepting traffic.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_init_seq.sv | 32 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the MEM-stage load/store sequencer.
package mem_pkg;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } mem_state_t;

endpackage

// File: rtl/mem_init_seq.sv
// Address counter for the post-reset memory sweep (used only when MEM_INIT_EN is defined).
// Stops on the all-ones address without wrapping and raises o_done after that write.
module mem_init_seq #(
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_count;
  logic              r_done;

  assign o_addr = r_count;
  assign o_last = i_en & (&r_count);
  assign o_done = r_done;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (i_en) begin
      if (&r_count) r_done <= 1'b1;
      else          r_count <= r_count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer driving a single-port synchronous data memory.
// Define MEM_INIT_EN to add a post-reset sweep that writes mem[i] = i before accepting traffic.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_rdata;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic              w_hs_req;
  logic              w_hs_rsp;
  logic              w_init_en;
  logic              w_init_last;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;

`ifdef MEM_INIT_EN
  localparam mem_state_t RST_STATE = ST_INIT;
  logic w_init_done;

  // The first INIT cycle after reset has mem_en low, so the counter only advances once writes are live.
  assign w_init_en = (r_state == ST_INIT) & r_mem_en;

  mem_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_init_en),
    .o_addr (w_init_addr),
    .o_last (w_init_last),
    .o_done (w_init_done)
  );

  assign init_done = w_init_done;
`else
  localparam mem_state_t RST_STATE = ST_IDLE;

  assign w_init_en   = 1'b0;
  assign w_init_last = 1'b0;
  assign w_init_addr = '0;
  assign init_done   = 1'b1;
`endif

  assign w_init_data = DATA_W'(w_init_addr);
  assign w_hs_req    = req_valid & r_req_ready;
  assign w_hs_rsp    = r_rsp_valid & rsp_ready;

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_INIT:   if (w_init_last) w_next = ST_IDLE;
      ST_IDLE:   if (w_hs_req)    w_next = ST_ACCESS;
      ST_ACCESS: w_next = r_mem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:   w_next = ST_RESP;
      ST_RESP:   if (w_hs_rsp)    w_next = ST_IDLE;
      default:   w_next = RST_STATE;
    endcase
  end

  // Handshake/strobe outputs are registered from the next state so they are all low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      r_mem_en    <= (w_next == ST_ACCESS) || (w_next == ST_INIT);
      r_mem_we    <= ((w_next == ST_ACCESS) && req_we) || (w_next == ST_INIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag       <= '0;
      r_rdata     <= '0;
      r_rsp_tag   <= '0;
    end else begin
      if (w_hs_req) begin
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_wdata;
        r_tag       <= req_tag;
      end else if (w_init_en) begin
        r_mem_addr  <= w_init_addr;
        r_mem_wdata <= w_init_data;
      end
      if (r_state == ST_WAIT) begin
        r_rdata   <= mem_rdata;
        r_rsp_tag <= r_tag;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_tag   = r_rsp_tag;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = (r_state == ST_INIT) ? w_init_addr : r_mem_addr;
  assign mem_wdata = (r_state == ST_INIT) ? w_init_data : r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 16-word synchronous memory model (ADDR_W = 4).
// Works with or without MEM_INIT_EN defined.
module tb_mem_access_unit;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TW = 4;
`ifdef MEM_INIT_EN
  localparam logic [DW-1:0] PRELOAD = 32'hA5A5_0000;
`else
  localparam logic [DW-1:0] PRELOAD = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [TW-1:0] rsp_tag;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          init_done;

  logic          preload;
  logic [DW-1:0] mem_model [16];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_tag   (rsp_tag),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_done (init_done)
  );

  // Single-port synchronous memory: read data appears the cycle after the sampled mem_en.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= PRELOAD | DW'(i);
    end else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
  endtask

  task automatic run_sweep();
    int n = 0;
    while (mem_en !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 16; i++) begin
      check("sweep_en_we", {mem_en, mem_we}, 2'b11);
      check("sweep_addr", 64'(mem_addr), 64'(i));
      check("sweep_data", 64'(mem_wdata), 64'(i));
      check("sweep_rdy_done_rsp", {req_ready, init_done, rsp_valid}, 3'b000);
      @(negedge clk);
    end
    check("sweep_end", {mem_en, init_done, req_ready}, 3'b011);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_req_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_tag = '0;
    @(negedge clk);
    check("st_en_we_rdy", {mem_en, mem_we, req_ready}, 3'b110);
    check("st_addr", 64'(mem_addr), 64'(a));
    check("st_data", 64'(mem_wdata), 64'(d));
    req_valid = 1'b0;
    @(negedge clk);
    check("st_done", {mem_en, req_ready, rsp_valid}, 3'b010);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input logic [DW-1:0] exp, input int hold, input logic early);
    wait_req_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_tag = t; rsp_ready = early;
    @(negedge clk);
    check("ld_access", {mem_en, mem_we, req_ready, rsp_valid}, 4'b1000);
    check("ld_addr", 64'(mem_addr), 64'(a));
    req_valid = 1'b0;
    @(negedge clk);
    check("ld_wait", {mem_en, rsp_valid, req_ready}, 3'b000);
    @(negedge clk);
    check("ld_rsp_valid", {rsp_valid, req_ready}, 2'b10);
    check("ld_rdata", 64'(rsp_rdata), 64'(exp));
    check("ld_tag", 64'(rsp_tag), 64'(t));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("ld_hold_valid", {rsp_valid, req_ready, mem_en}, 3'b100);
      check("ld_hold_rdata", 64'(rsp_rdata), 64'(exp));
      check("ld_hold_tag", 64'(rsp_tag), 64'(t));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ld_complete", {rsp_valid, req_ready}, 2'b01);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    check("rst_ctrl", {req_ready, rsp_valid, mem_en, mem_we}, 4'b0000);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, '0);
    check("rst_rsp", {rsp_rdata, rsp_tag}, '0);
`ifdef MEM_INIT_EN
    check("rst_init_done", 64'(init_done), 64'd0);
    rst_n = 1'b1;
    run_sweep();
`else
    check("rst_init_done", 64'(init_done), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {req_ready, init_done}, 2'b11);
`endif

    do_store(4'd5, 32'hDEAD_BEEF);
    do_load(4'd5, 4'd3, 32'hDEAD_BEEF, 0, 1'b1);
    do_load(4'd15, 4'd1, 32'd15 | PRELOAD & 32'h0, 5, 1'b0);
    do_load(4'd0, 4'd2, 32'd0, 0, 1'b0);

    // Back-to-back stores with req_valid held high: one accepted every other edge.
    wait_req_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd8; req_wdata = 32'h108;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("b2b_en", 64'(mem_en), 64'((k % 2) == 0));
      check("b2b_ready", 64'(req_ready), 64'((k % 2) == 1));
      if ((k % 2) == 0) check("b2b_addr", 64'(mem_addr), 64'(8 + k / 2));
      if (k == 1 || k == 3) begin
        req_addr  = AW'(8 + (k + 1) / 2);
        req_wdata = 32'h100 + DW'(8 + (k + 1) / 2);
      end
    end
    req_valid = 1'b0;
    do_load(4'd9, 4'd4, 32'h109, 0, 1'b1);
    do_load(4'd10, 4'd6, 32'h10A, 0, 1'b1);

    // Reset asserted while a load is in WAIT.
    wait_req_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; req_tag = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {req_ready, rsp_valid, mem_en, mem_we}, 4'b0000);
    check("mid_rst_addr_wdata", {mem_addr, mem_wdata}, '0);
    check("mid_rst_rsp", {rsp_rdata, rsp_tag}, '0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MEM_INIT_EN
    run_sweep();
    do_load(4'd5, 4'd3, 32'd5, 0, 1'b1);
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {rsp_valid, req_ready}, 2'b01);
    end
    do_load(4'd5, 4'd3, 32'hDEAD_BEEF, 0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
